// File: rtl/fpga_mem_arbiter_if.sv
// rtl/fpga_mem_arbiter_if.sv - Avalon-MM style single-beat bus shared by requesters and the fpga_mem master
interface fpga_mem_arbiter_if #(
   parameter int ADDR_W = 27,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   address;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W/8-1:0] byteenable;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/fpga_mem_arbiter.sv
// rtl/fpga_mem_arbiter.sv - two-requester round-robin arbiter for the HPS fpga_mem Avalon-MM master
// One command per grant; read responses are steered back in order through a grant-ID FIFO.
module fpga_mem_arbiter #(
   parameter int ADDR_W      = 27,
   parameter int DATA_W      = 32,
   parameter int MAX_PENDING = 4
) (
   input  logic                            clk100_clk,
   input  logic                            reset_clk100_reset_n,
   fpga_mem_arbiter_if.slave               s0,
   fpga_mem_arbiter_if.slave               s1,
   fpga_mem_arbiter_if.master              m,
   output logic                            m_burstcount,
   output logic                            m_debugaccess,
   output logic [$clog2(MAX_PENDING):0]    pending_cnt,
   output logic                            rsp_err
);
   localparam int PW = $clog2(MAX_PENDING);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, BUSY} state_e;

   state_e              state_q;
   logic                grant_q;
   logic                last_q;
   logic                grant_d;
   logic [MAX_PENDING-1:0] id_fifo_q;
   logic [PW-1:0]       wr_ptr_q;
   logic [PW-1:0]       rd_ptr_q;
   logic [CW-1:0]       cnt_q;
   logic [CW-1:0]       cnt_d;
   logic                rsp_err_q;

   logic                full;
   logic                empty;
   logic                elig0;
   logic                elig1;
   logic                busy;
   logic                sel_read;
   logic                sel_write;
   logic                accept;
   logic                push;
   logic                pop;
   logic                head;

   assign full  = (cnt_q == CW'(MAX_PENDING));
   assign empty = (cnt_q == '0);

   // Eligibility uses the registered count, so a same-cycle pop never unblocks a read.
   assign elig0 = s0.write | (s0.read & ~full);
   assign elig1 = s1.write | (s1.read & ~full);
   assign grant_d = (elig0 & elig1) ? ~last_q : elig1;

   assign busy      = (state_q == BUSY);
   assign sel_read  = grant_q ? s1.read  : s0.read;
   assign sel_write = grant_q ? s1.write : s0.write;

   assign m.address    = grant_q ? s1.address    : s0.address;
   assign m.writedata  = grant_q ? s1.writedata  : s0.writedata;
   assign m.byteenable = grant_q ? s1.byteenable : s0.byteenable;
   assign m.write      = busy & sel_write;
   assign m.read       = busy & sel_read & ~sel_write & ~full;
   assign m_burstcount  = 1'b1;
   assign m_debugaccess = 1'b0;

   assign s0.waitrequest = (busy & ~grant_q) ? m.waitrequest : 1'b1;
   assign s1.waitrequest = (busy &  grant_q) ? m.waitrequest : 1'b1;

   assign accept = (m.read | m.write) & ~m.waitrequest;
   assign push   = accept & m.read;
   assign pop    = m.readdatavalid & ~empty;
   assign head   = id_fifo_q[rd_ptr_q];

   assign s0.readdatavalid = pop & ~head;
   assign s1.readdatavalid = pop &  head;
   assign s0.readdata      = m.readdata;
   assign s1.readdata      = m.readdata;

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk100_clk or negedge reset_clk100_reset_n) begin
      if (!reset_clk100_reset_n) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (elig0 | elig1) begin
                  grant_q <= grant_d;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (accept) begin
                  last_q  <= grant_q;
                  state_q <= IDLE;
               end else if (!(sel_read | sel_write)) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Reset flushes the ID FIFO; late responses afterwards land in rsp_err.
   always_ff @(posedge clk100_clk or negedge reset_clk100_reset_n) begin
      if (!reset_clk100_reset_n) begin
         id_fifo_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         if (push) begin
            id_fifo_q[wr_ptr_q] <= grant_q;
            wr_ptr_q            <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         cnt_q <= cnt_d;
         if (m.readdatavalid && empty) begin
            rsp_err_q <= 1'b1;
         end
      end
   end

   assign pending_cnt = cnt_q;
   assign rsp_err     = rsp_err_q;
endmodule

// File: tb/tb_fpga_mem_arbiter.sv
// tb/tb_fpga_mem_arbiter.sv - scoreboard bench for fpga_mem_arbiter
module tb_fpga_mem_arbiter;
   localparam int ADDR_W = 27;
   localparam int DATA_W = 32;
   localparam int MAX_PENDING = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       m_burstcount;
   logic       m_debugaccess;
   logic [2:0] pending_cnt;
   logic       rsp_err;

   fpga_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s0_if ();
   fpga_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s1_if ();
   fpga_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

   fpga_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAX_PENDING)) dut (
      .clk100_clk           (clk),
      .reset_clk100_reset_n (rst_n),
      .s0                   (s0_if),
      .s1                   (s1_if),
      .m                    (m_if),
      .m_burstcount         (m_burstcount),
      .m_debugaccess        (m_debugaccess),
      .pending_cnt          (pending_cnt),
      .rsp_err              (rsp_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic [31:0] s0_q[$];
   logic [31:0] s1_q[$];
   logic [31:0] wexp_q[$];
   logic [ADDR_W-1:0] mem_q[$];
   int wr_cycles[$];
   bit resp_en = 0;
   bit spurious = 0;
   bit s0_rdv_seen = 0;
   int peak = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory side: capture accepted reads, answer with data = address.
   always @(negedge clk) begin
      if (m_if.read && !m_if.waitrequest) mem_q.push_back(m_if.address);
      if (m_if.write && !m_if.waitrequest) begin
         if (wexp_q.size() == 0) check("wr_unexpected", 1, 0);
         else check("wr_data", m_if.writedata, wexp_q.pop_front());
         wr_cycles.push_back(cyc);
      end
      if (int'(pending_cnt) > peak) peak = int'(pending_cnt);
   end

   initial begin
      m_if.readdatavalid = 1'b0;
      m_if.readdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (spurious) begin
            m_if.readdatavalid = 1'b1;
            m_if.readdata = 32'hDEAD_BEEF;
            spurious = 0;
         end else if (resp_en && mem_q.size() > 0) begin
            m_if.readdatavalid = 1'b1;
            m_if.readdata = {5'b0, mem_q.pop_front()};
         end else begin
            m_if.readdatavalid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (s0_if.readdatavalid) begin
         s0_rdv_seen = 1;
         if (s0_q.size() == 0) check("s0_rdv_unexpected", 1, 0);
         else check("s0_rdata", s0_if.readdata, s0_q.pop_front());
      end
      if (s1_if.readdatavalid) begin
         if (s1_q.size() == 0) check("s1_rdv_unexpected", 1, 0);
         else check("s1_rdata", s1_if.readdata, s1_q.pop_front());
      end
   end

   task automatic set_req(input int id, input logic rd, input logic wr,
                          input logic [ADDR_W-1:0] a, input logic [31:0] d);
      if (id == 0) begin
         s0_if.read = rd; s0_if.write = wr; s0_if.address = a;
         s0_if.writedata = d; s0_if.byteenable = 4'hF;
      end else begin
         s1_if.read = rd; s1_if.write = wr; s1_if.address = a;
         s1_if.writedata = d; s1_if.byteenable = 4'hF;
      end
   endtask

   task automatic wait_accept(input int id, input string tag);
      bit done = 0;
      int n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         if (id == 0) done = (s0_if.read | s0_if.write) & ~s0_if.waitrequest;
         else         done = (s1_if.read | s1_if.write) & ~s1_if.waitrequest;
         n++;
      end
      if (!done) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((s0_q.size() != 0 || s1_q.size() != 0 || pending_cnt != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_pending"}, pending_cnt, 0);
      check({tag, "_outstanding"}, s0_q.size() + s1_q.size(), 0);
   endtask

   task automatic writer(input int id, input int n);
      for (int k = 0; k < n; k++) begin
         set_req(id, 0, 1, ADDR_W'(32'h200 + id * 16 + k), (id == 0 ? 32'h1000_0000 : 32'h2000_0000) + k);
         wait_accept(id, "alt_wr");
         @(posedge clk); #1;
      end
      set_req(id, 0, 0, '0, '0);
   endtask

   initial begin
      set_req(0, 0, 0, '0, '0);
      set_req(1, 0, 0, '0, '0);
      m_if.waitrequest = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_pending", pending_cnt, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_m_read", m_if.read, 0);
      check("rst_m_write", m_if.write, 0);
      check("rst_s0_wait", s0_if.waitrequest, 1);
      check("rst_s1_wait", s1_if.waitrequest, 1);
      check("rst_s0_rdv", s0_if.readdatavalid, 0);
      check("rst_burstcount", m_burstcount, 1);
      check("rst_debugaccess", m_debugaccess, 0);

      // Reads held across reset release: 0 then 1.
      @(posedge clk); #1;
      set_req(0, 1, 0, ADDR_W'(32'h10), '0);
      set_req(1, 1, 0, ADDR_W'(32'h20), '0);
      s0_q.push_back(32'h10);
      s1_q.push_back(32'h20);
      rst_n = 1'b1;
      @(negedge clk);
      check("c1_m_read", m_if.read, 0);
      @(negedge clk);
      check("c2_m_read", m_if.read, 1);
      check("c2_addr", m_if.address, 32'h10);
      check("c2_s0_wait", s0_if.waitrequest, 0);
      check("c2_s1_wait", s1_if.waitrequest, 1);
      @(posedge clk); #1;
      set_req(0, 0, 0, '0, '0);
      @(negedge clk);
      check("c3_m_read", m_if.read, 0);
      check("c3_pending", pending_cnt, 1);
      @(negedge clk);
      check("c4_m_read", m_if.read, 1);
      check("c4_addr", m_if.address, 32'h20);
      check("c4_s1_wait", s1_if.waitrequest, 0);
      @(posedge clk); #1;
      set_req(1, 0, 0, '0, '0);
      @(negedge clk);
      check("c5_pending", pending_cnt, 2);
      resp_en = 1;
      drain("rr_reads");

      // Both requesters writing continuously: strict alternation, one command per 2 cycles.
      resp_en = 0;
      wr_cycles.delete();
      for (int k = 0; k < 4; k++) begin
         wexp_q.push_back(32'h1000_0000 + k);
         wexp_q.push_back(32'h2000_0000 + k);
      end
      @(posedge clk); #1;
      fork
         writer(0, 4);
         writer(1, 4);
      join
      check("alt_wr_left", wexp_q.size(), 0);
      check("alt_wr_count", wr_cycles.size(), 8);
      for (int i = 1; i < wr_cycles.size(); i++)
         check("alt_wr_spacing", wr_cycles[i] - wr_cycles[i-1], 2);

      // Requester 1 write stalled by m_waitrequest for 5 cycles; s0 requests meanwhile.
      wexp_q.push_back(32'h3000_0001);
      wexp_q.push_back(32'h3000_0002);
      @(posedge clk); #1;
      m_if.waitrequest = 1'b1;
      set_req(1, 0, 1, ADDR_W'(32'h300), 32'h3000_0001);
      @(posedge clk); #1;
      set_req(0, 0, 1, ADDR_W'(32'h304), 32'h3000_0002);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_s1_wait", s1_if.waitrequest, 1);
         check("stall_s0_wait", s0_if.waitrequest, 1);
         check("stall_m_write", m_if.write, 1);
         check("stall_m_wdata", m_if.writedata, 32'h3000_0001);
      end
      @(posedge clk); #1;
      m_if.waitrequest = 1'b0;
      @(negedge clk);
      check("stall_s1_release", s1_if.waitrequest, 0);
      check("stall_s0_held", s0_if.waitrequest, 1);
      @(posedge clk); #1;
      set_req(1, 0, 0, '0, '0);
      wait_accept(0, "stall_s0");
      @(posedge clk); #1;
      set_req(0, 0, 0, '0, '0);
      check("stall_wr_left", wexp_q.size(), 0);

      // Four outstanding reads fill the FIFO; the fifth waits for a response.
      peak = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         set_req(0, 1, 0, ADDR_W'(32'h100 + k), '0);
         s0_q.push_back(32'h100 + k);
         wait_accept(0, "fill_rd");
         @(posedge clk); #1;
         set_req(0, 0, 0, '0, '0);
      end
      set_req(0, 1, 0, ADDR_W'(32'h104), '0);
      s0_q.push_back(32'h104);
      s0_rdv_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("full_s0_wait", s0_if.waitrequest, 1);
         check("full_pending", pending_cnt, 4);
         check("full_m_read", m_if.read, 0);
      end
      resp_en = 1;
      wait_accept(0, "fifth_rd");
      check("fifth_after_rdv", s0_rdv_seen, 1);
      @(posedge clk); #1;
      set_req(0, 0, 0, '0, '0);
      drain("fill");
      check("fill_peak", peak, 4);

      // Interleaved reads 0,1,0.
      resp_en = 0;
      @(posedge clk); #1;
      set_req(0, 1, 0, ADDR_W'(32'hA), '0); s0_q.push_back(32'hA);
      wait_accept(0, "il_a");
      @(posedge clk); #1;
      set_req(0, 0, 0, '0, '0);
      set_req(1, 1, 0, ADDR_W'(32'hB), '0); s1_q.push_back(32'hB);
      wait_accept(1, "il_b");
      @(posedge clk); #1;
      set_req(1, 0, 0, '0, '0);
      set_req(0, 1, 0, ADDR_W'(32'hC), '0); s0_q.push_back(32'hC);
      wait_accept(0, "il_c");
      @(posedge clk); #1;
      set_req(0, 0, 0, '0, '0);
      @(negedge clk);
      check("il_pending", pending_cnt, 3);
      resp_en = 1;
      drain("il");

      // Response with nothing pending.
      check("pre_rsp_err", rsp_err, 0);
      resp_en = 0;
      @(negedge clk);
      spurious = 1;
      @(posedge clk); #2;
      @(negedge clk);
      check("spur_s0_rdv", s0_if.readdatavalid, 0);
      check("spur_s1_rdv", s1_if.readdatavalid, 0);
      @(negedge clk);
      check("spur_rsp_err", rsp_err, 1);
      repeat (5) @(negedge clk);
      check("spur_rsp_err_sticky", rsp_err, 1);
      check("spur_pending", pending_cnt, 0);

      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("rst2_rsp_err", rsp_err, 0);
      check("rst2_s0_wait", s0_if.waitrequest, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
